// File: rtl/life_sequencer.sv
// Control sequencer for the 64-cell Life engine: seeds from the LFSR, then paces generations.
// grid_en/load_sel/lfsr_reset decode the registered state; status outputs are registered.
module life_sequencer #(
    parameter int GEN_W       = 16,
    parameter int DIV_W       = 8,
    parameter int SEED_CYCLES = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_single_step,
    input  logic             i_randomize,
    input  logic [DIV_W-1:0] i_rate_div,
    input  logic [GEN_W-1:0] i_max_gen,
    input  logic [63:0]      i_grid_cur,
    input  logic [63:0]      i_grid_next,
    output logic             o_lfsr_reset,
    output logic             o_load_sel,
    output logic             o_grid_en,
    output logic [GEN_W-1:0] o_gen_count,
    output logic             o_running,
    output logic             o_halted,
    output logic [1:0]       o_halt_cause
);

    localparam int SEED_W = (SEED_CYCLES < 2) ? 1 : $clog2(SEED_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DIV_W-1:0]   r_tick;
    logic [SEED_W-1:0]  r_seed_cnt;
    logic [GEN_W-1:0]   r_gen;
    logic               r_running;
    logic               r_halted;
    logic [1:0]         r_cause;

    logic               w_tick_hit;
    logic               w_step;
    logic               w_update;
    logic [GEN_W-1:0]   w_gen_inc;
    logic [1:0]         w_cause;
    logic               w_halt;
    logic               w_enter_seed;
    logic               w_seed_done;

    assign w_tick_hit  = (r_tick == i_rate_div);
    // randomize and start both outrank single_step while paused
    assign w_step      = (r_state == S_PAUSE) && i_single_step && !i_randomize && !i_start;
    assign w_update    = ((r_state == S_RUN) && w_tick_hit) || w_step;
    assign w_gen_inc   = r_gen + GEN_W'(1);
    assign w_seed_done = (r_seed_cnt == SEED_W'(SEED_CYCLES - 1));

    always_comb begin
        w_cause = 2'b00;
        if (i_grid_next == 64'd0) begin
            w_cause = 2'b01;
        end else if (i_grid_next == i_grid_cur) begin
            w_cause = 2'b10;
        end else if ((i_max_gen != '0) && (w_gen_inc == i_max_gen)) begin
            w_cause = 2'b11;
        end
    end

    assign w_halt = w_update && (w_cause != 2'b00);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (i_start || i_randomize) w_next_state = S_SEED;
            S_SEED:  if (w_seed_done) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_RUN;
            S_RUN: begin
                // a halt on the update cycle outranks a pause or reseed request
                if (w_halt)           w_next_state = S_HALT;
                else if (i_stop)      w_next_state = S_PAUSE;
                else if (i_randomize) w_next_state = S_SEED;
            end
            S_PAUSE: begin
                if (i_randomize)  w_next_state = S_SEED;
                else if (i_start) w_next_state = S_RUN;
                else if (w_halt)  w_next_state = S_HALT;
            end
            S_HALT:  if (i_start || i_randomize) w_next_state = S_SEED;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_enter_seed = (w_next_state == S_SEED) && (r_state != S_SEED);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_seed_cnt <= '0;
            r_gen      <= '0;
            r_running  <= 1'b0;
            r_halted   <= 1'b0;
            r_cause    <= 2'b00;
        end else begin
            r_state   <= w_next_state;
            r_running <= (w_next_state == S_RUN);
            r_halted  <= (w_next_state == S_HALT);
            if (w_enter_seed) begin
                r_gen      <= '0;
                r_cause    <= 2'b00;
                r_tick     <= '0;
                r_seed_cnt <= '0;
            end else begin
                if (r_state == S_SEED) begin
                    r_seed_cnt <= r_seed_cnt + SEED_W'(1);
                end
                if (w_update) begin
                    r_gen <= (&r_gen) ? r_gen : w_gen_inc;
                    if (w_halt) begin
                        r_cause <= w_cause;
                    end
                end
                // the tick is frozen while paused so a resume continues the interval
                if (r_state == S_RUN) begin
                    if (w_tick_hit) begin
                        r_tick <= '0;
                    end else if (w_next_state == S_RUN) begin
                        r_tick <= r_tick + DIV_W'(1);
                    end
                end
            end
        end
    end

    assign o_lfsr_reset = (r_state == S_IDLE);
    assign o_load_sel   = (r_state == S_LOAD);
    assign o_grid_en    = (r_state == S_LOAD) || w_update;
    assign o_gen_count  = r_gen;
    assign o_running    = r_running;
    assign o_halted     = r_halted;
    assign o_halt_cause = r_cause;

endmodule

// File: tb/tb_life_sequencer.sv
// Randomized and directed stimulus for life_sequencer against a cycle-level behavioural model.
module tb_life_sequencer;

    localparam int GW = 16;
    localparam int DW = 8;
    localparam int SC = 8;

    localparam int MD_IDLE  = 0;
    localparam int MD_SEED  = 1;
    localparam int MD_LOAD  = 2;
    localparam int MD_RUN   = 3;
    localparam int MD_PAUSE = 4;
    localparam int MD_HALT  = 5;

    logic          clk = 1'b0;
    logic          reset, start, stop, single_step, randomize;
    logic [DW-1:0] rate_div;
    logic [GW-1:0] max_gen;
    logic [63:0]   grid_cur, grid_next;
    logic          lfsr_reset, load_sel, grid_en, running, halted;
    logic [GW-1:0] gen_count;
    logic [1:0]    halt_cause;

    always #5 clk = ~clk;

    life_sequencer #(.GEN_W(GW), .DIV_W(DW), .SEED_CYCLES(SC)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_stop       (stop),
        .i_single_step(single_step),
        .i_randomize  (randomize),
        .i_rate_div   (rate_div),
        .i_max_gen    (max_gen),
        .i_grid_cur   (grid_cur),
        .i_grid_next  (grid_next),
        .o_lfsr_reset (lfsr_reset),
        .o_load_sel   (load_sel),
        .o_grid_en    (grid_en),
        .o_gen_count  (gen_count),
        .o_running    (running),
        .o_halted     (halted),
        .o_halt_cause (halt_cause)
    );

    // behavioural model state
    int            m_mode      = MD_IDLE;
    int            m_seed_left = 0;
    int            m_tick      = 0;
    int            m_gen       = 0;
    int            m_cause     = 0;
    logic          e_en, e_load;

    int            n_vec = 0;
    int            n_err = 0;
    int            en_pulses = 0;
    int            force_kind = 0;
    int            force_at = 0;
    int            rnd_gn = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (v == 64'd0) v = 64'd1;
        return v;
    endfunction

    function automatic logic model_update();
        return (m_mode == MD_RUN && m_tick == int'(rate_div)) ||
               (m_mode == MD_PAUSE && single_step && !start && !randomize);
    endfunction

    task automatic enter_seed();
        m_mode = MD_SEED; m_seed_left = SC; m_gen = 0; m_cause = 0; m_tick = 0;
    endtask

    task automatic model_step();
        logic upd;
        int   c;
        if (reset) begin
            m_mode = MD_IDLE; m_seed_left = 0; m_tick = 0; m_gen = 0; m_cause = 0;
            return;
        end
        upd = model_update();
        c = 0;
        if (upd) begin
            if (grid_next == 64'd0)                                   c = 1;
            else if (grid_next == grid_cur)                           c = 2;
            else if (max_gen != 0 && ((m_gen + 1) % 65536) == int'(max_gen)) c = 3;
            if (m_gen < 65535) m_gen = m_gen + 1;
        end
        case (m_mode)
            MD_IDLE: if (start || randomize) enter_seed();
            MD_SEED: begin
                m_seed_left = m_seed_left - 1;
                if (m_seed_left == 0) m_mode = MD_LOAD;
            end
            MD_LOAD: m_mode = MD_RUN;
            MD_RUN: begin
                if (upd) m_tick = 0;
                else if (!stop && !randomize) m_tick = (m_tick + 1) % 256;
                if (c != 0) begin m_mode = MD_HALT; m_cause = c; end
                else if (stop) m_mode = MD_PAUSE;
                else if (randomize) enter_seed();
            end
            MD_PAUSE: begin
                if (randomize) enter_seed();
                else if (start) m_mode = MD_RUN;
                else if (c != 0) begin m_mode = MD_HALT; m_cause = c; end
            end
            default: if (start || randomize) enter_seed();
        endcase
    endtask

    task automatic check_outputs();
        e_en   = (m_mode == MD_LOAD) || model_update();
        e_load = (m_mode == MD_LOAD);
        chk("lfsr_reset", lfsr_reset, m_mode == MD_IDLE);
        chk("load_sel", load_sel, e_load);
        chk("grid_en", grid_en, e_en);
        chk("gen_count", gen_count, m_gen);
        chk("running", running, m_mode == MD_RUN);
        chk("halted", halted, m_mode == MD_HALT);
        chk("halt_cause", halt_cause, m_cause);
        if (grid_en === 1'b1) en_pulses++;
    endtask

    // one clock: choose grid_next, check before the edge, advance model and grid after it
    task automatic run_cycle();
        int kind;
        kind = 0;
        if (force_kind != 0 && m_gen == force_at - 1) kind = force_kind;
        else if (rnd_gn != 0) begin
            case ($urandom_range(0, 9))
                0: kind = 1;
                1: kind = 2;
                default: kind = 0;
            endcase
        end
        if (kind == 1)      grid_next = 64'd0;
        else if (kind == 2) grid_next = grid_cur;
        else begin
            grid_next = rand64();
            if (grid_next == grid_cur) grid_next = ~grid_cur | 64'd1;
        end
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        model_step();
        if (e_en) grid_cur = e_load ? rand64() : grid_next;
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        reset = 0; start = 0; stop = 0; single_step = 0; randomize = 0;
    endtask

    task automatic do_reset();
        clear_ctl();
        reset = 1;
        run_cycle();
        run_cycle();
        reset = 0;
    endtask

    // start at cycle k: LOAD at k+9, updates at k+12/15/18 with rate_div=2
    task automatic nominal(input string tag);
        rate_div = 2; max_gen = 0;
        start = 1;
        en_pulses = 0;
        run_cycle();
        start = 0;
        repeat (18) run_cycle();
        chk({tag, "_en_pulses"}, en_pulses, 4);
        chk({tag, "_gen"}, gen_count, 3);
        chk({tag, "_running"}, running, 1);
    endtask

    initial begin
        clear_ctl();
        reset = 1;
        rate_div = 2; max_gen = 0;
        grid_cur = 64'h1; grid_next = 64'h2;
        @(negedge clk);
        do_reset();
        chk("rst_lfsr", lfsr_reset, 1);
        chk("rst_gen", gen_count, 0);
        chk("rst_halted", halted, 0);

        nominal("nom");

        // extinction on the third update
        do_reset();
        force_kind = 1; force_at = 3;
        start = 1; run_cycle(); start = 0;
        repeat (30) run_cycle();
        chk("ext_halted", halted, 1);
        chk("ext_cause", halt_cause, 2'b01);
        chk("ext_gen", gen_count, 3);
        en_pulses = 0;
        repeat (10) run_cycle();
        chk("ext_quiet", en_pulses, 0);

        // still-life on the first update
        do_reset();
        force_kind = 2; force_at = 1;
        start = 1; run_cycle(); start = 0;
        repeat (20) run_cycle();
        chk("still_cause", halt_cause, 2'b10);
        chk("still_gen", gen_count, 1);

        // generation limit
        do_reset();
        force_kind = 0; max_gen = 5;
        start = 1; run_cycle(); start = 0;
        repeat (40) run_cycle();
        chk("max_cause", halt_cause, 2'b11);
        chk("max_gen", gen_count, 5);

        // pause at tick 1, two single steps, resume
        do_reset();
        max_gen = 0;
        start = 1; run_cycle(); start = 0;
        rate_div = 3;
        repeat (10) run_cycle();
        stop = 1; run_cycle(); stop = 0;
        en_pulses = 0;
        repeat (20) run_cycle();
        chk("pause_quiet", en_pulses, 0);
        single_step = 1; run_cycle(); single_step = 0;
        repeat (2) run_cycle();
        single_step = 1; run_cycle(); single_step = 0;
        run_cycle();
        chk("step_pulses", en_pulses, 2);
        chk("step_gen", gen_count, 2);
        en_pulses = 0;
        start = 1; run_cycle(); start = 0;
        repeat (2) run_cycle();
        chk("resume_early", en_pulses, 0);
        run_cycle();
        chk("resume_first", en_pulses, 1);
        chk("resume_gen", gen_count, 3);

        // simultaneous requests
        start = 1; stop = 1; run_cycle(); clear_ctl();
        chk("startstop_running", running, 0);
        randomize = 1; start = 1; run_cycle(); clear_ctl();
        chk("rand_start_gen", gen_count, 0);
        chk("rand_start_lfsr", lfsr_reset, 0);
        do_reset();
        rate_div = 2; max_gen = 1; force_kind = 1; force_at = 1;
        start = 1; run_cycle(); start = 0;
        repeat (20) run_cycle();
        chk("ext_vs_max_cause", halt_cause, 2'b01);
        force_kind = 0; max_gen = 0;

        // reset mid-SEED and mid-RUN, then replay nominal timing
        do_reset();
        start = 1; run_cycle(); start = 0;
        repeat (4) run_cycle();
        reset = 1; run_cycle(); reset = 0;
        chk("rs_seed_lfsr", lfsr_reset, 1);
        chk("rs_seed_en", grid_en, 0);
        nominal("replay1");
        repeat (5) run_cycle();
        reset = 1; run_cycle(); reset = 0;
        chk("rs_run_running", running, 0);
        chk("rs_run_gen", gen_count, 0);
        nominal("replay2");

        // random traffic
        rnd_gn = 1;
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) begin
                rate_div = DW'($urandom_range(0, 4));
                max_gen  = GW'($urandom_range(0, 7));
            end
            reset       = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 14) == 0);
            stop        = ($urandom_range(0, 19) == 0);
            single_step = ($urandom_range(0, 7) == 0);
            randomize   = ($urandom_range(0, 39) == 0);
            run_cycle();
        end
        clear_ctl();
        run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
